// File: rtl/perm_drain.sv
// -----------------------------------------------------------------------------
// perm_drain
// Transmit side of the lane-stream protocol. Reads the 5x5 lane state out of a
// combinational lane memory and streams the first N lanes (x-fastest order:
// x0y0, x1y0 .. x4y0, x0y1 .. x4y4) with a push/stop handshake. N comes from
// rate_lanes, so one block serves both squeeze (rate lanes) and full dumps.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst         in   synchronous reset, active low
//   start       in   one-cycle drain request, honoured only when idle
//   rate_lanes  in   lanes to send (1..25); 0 or >25 means 25
//   busy        out  drain in progress
//   done        out  one-cycle pulse after the last lane is accepted
//   mrx, mry    out  lane memory read index (next lane to load)
//   mrd         in   lane memory read data, same cycle as mrx/mry
//   pushout     out  dout/firstout valid
//   stopout     in   downstream backpressure
//   firstout    out  marks lane x0y0 of each drain
//   dout        out  lane data (registered)
//
// state | meaning
// IDLE  | waiting for start, pointer parked at (0,0)
// SEND  | presenting a lane on dout, waiting for it to be accepted
// DONE  | last lane accepted, done pulse, busy drops afterwards
// -----------------------------------------------------------------------------
module perm_drain #(
  parameter int DW     = 64,
  parameter int NLANES = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    rate_lanes,
  output logic          busy,
  output logic          done,
  output logic [2:0]    mrx,
  output logic [2:0]    mry,
  input  logic [DW-1:0] mrd,
  output logic          pushout,
  input  logic          stopout,
  output logic          firstout,
  output logic [DW-1:0] dout
);

  localparam logic [4:0] NL = 5'(NLANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    x_q, x_d, y_q, y_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    n_q, n_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          push_q, push_d;
  logic          first_q, first_d;
  logic          busy_q, busy_d;

  logic [4:0]    rate_clamped;
  logic          xfer;
  logic [2:0]    x_inc, y_inc;

  assign rate_clamped = ((rate_lanes == 5'd0) || (rate_lanes > NL)) ? NL : rate_lanes;
  assign xfer         = push_q & ~stopout;

  // x-fastest walk over the 5x5 grid; (4,4) wraps back to (0,0)
  always_comb begin
    x_inc = x_q + 3'd1;
    y_inc = y_q;
    if (x_q == 3'd4) begin
      x_inc = 3'd0;
      y_inc = (y_q == 3'd4) ? 3'd0 : y_q + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    dout_d  = dout_q;
    push_d  = push_q;
    first_d = first_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        x_d = 3'd0;
        y_d = 3'd0;
        if (start) begin
          // pointer is (0,0) here, so mrd is lane x0y0
          dout_d  = mrd;
          push_d  = 1'b1;
          first_d = 1'b1;
          busy_d  = 1'b1;
          n_d     = rate_clamped;
          cnt_d   = 5'd1;
          x_d     = 3'd1;
          y_d     = 3'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          first_d = 1'b0;
          if (cnt_q < n_q) begin
            dout_d = mrd;
            cnt_d  = cnt_q + 5'd1;
            x_d    = x_inc;
            y_d    = y_inc;
          end else begin
            push_d  = 1'b0;
            x_d     = 3'd0;
            y_d     = 3'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      cnt_q   <= 5'd0;
      n_q     <= 5'd0;
      dout_q  <= '0;
      push_q  <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      dout_q  <= dout_d;
      push_q  <= push_d;
      first_q <= first_d;
      busy_q  <= busy_d;
    end
  end

  assign mrx      = x_q;
  assign mry      = y_q;
  assign dout     = dout_q;
  assign pushout  = push_q;
  assign firstout = first_q;
  assign busy     = busy_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_perm_drain.sv
// -----------------------------------------------------------------------------
// tb_perm_drain
// Directed sequence of drains against perm_drain. The lane memory is modelled
// as a 25-entry array indexed y*5+x; expected beats are simply mem[0..N-1] in
// order, with N derived from the rate clamp rule.
// -----------------------------------------------------------------------------
module tb_perm_drain;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  rate_lanes;
  logic        busy;
  logic        done;
  logic [2:0]  mrx;
  logic [2:0]  mry;
  logic [63:0] mrd;
  logic        pushout;
  logic        stopout;
  logic        firstout;
  logic [63:0] dout;

  logic [63:0] mem [25];
  int n_asrt = 0;
  int n_fail = 0;

  perm_drain #(.DW(64), .NLANES(25)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rate_lanes (rate_lanes),
    .busy       (busy),
    .done       (done),
    .mrx        (mrx),
    .mry        (mry),
    .mrd        (mrd),
    .pushout    (pushout),
    .stopout    (stopout),
    .firstout   (firstout),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mrd = '0;
    if (mrx < 3'd5 && mry < 3'd5) mrd = mem[int'(mry) * 5 + int'(mrx)];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] lane_yx(input int lane);
    int p;
    p = lane % 25;
    return {3'(p / 5), 3'(p % 5)};
  endfunction

  // mode 0: no backpressure, mode 1: random stalls, mode 2: stall beat 7 for 3 clks
  // inject: pulse start mid-drain and in the DONE cycle (the latter leaves start
  // high into the next call, which must observe that it was ignored)
  task automatic run_drain(input logic [4:0] rate, input int mode, input bit inject);
    int n, idx, st7, seen7;
    bit fin, stall;
    n = (rate == 5'd0 || rate > 5'd25) ? 25 : int'(rate);
    @(negedge clk);
    chk("idle_push", 64'(pushout), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_ptr", 64'({mry, mrx}), 64'd0);
    start = 1'b1;
    rate_lanes = rate;
    stopout = 1'b0;
    idx = 0; fin = 1'b0; st7 = 0; seen7 = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && idx == 5) begin
        start = 1'b1;
        rate_lanes = 5'd2;
      end
      if (pushout) begin
        if (idx >= n) begin
          chk("overrun", 64'(idx), 64'(n - 1));
          fin = 1'b1;
        end else begin
          chk("dout", dout, mem[idx]);
          chk("firstout", 64'(firstout), 64'(idx == 0));
          chk("send_busy", 64'(busy), 64'd1);
          chk("send_done", 64'(done), 64'd0);
          chk("ptr", 64'({mry, mrx}), 64'(lane_yx(idx + 1)));
          if (idx == 7) seen7++;
          stall = 1'b0;
          if (mode == 1) stall = ($urandom_range(0, 3) == 0);
          if (mode == 2 && idx == 7 && st7 < 3) begin
            stall = 1'b1;
            st7++;
          end
          stopout = stall;
          if (!stall) idx++;
        end
      end else begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("xfer_count", 64'(idx), 64'(n));
        if (mode == 0) chk("throughput", 64'(c), 64'(n));
        if (mode == 2) chk("hold_beat7", 64'(seen7), 64'd4);
        fin = 1'b1;
        stopout = 1'b0;
        if (inject) begin
          start = 1'b1;
          rate_lanes = 5'd4;
        end
      end
    end
    if (!fin) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    rate_lanes = 5'd0;
    stopout = 1'b0;
    for (int i = 0; i < 25; i++) mem[i] = 64'(i);

    repeat (3) @(negedge clk);
    chk("rst_push", 64'(pushout), 64'd0);
    chk("rst_first", 64'(firstout), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ptr", 64'({mry, mrx}), 64'd0);
    rst = 1'b1;

    // T1: lane i holds i, full state, no backpressure
    run_drain(5'd25, 0, 1'b0);

    for (int i = 0; i < 25; i++) mem[i] = {$urandom, $urandom};

    // T2: stall during beat 7
    run_drain(5'd25, 2, 1'b0);
    // T3: SHA3-256 rate
    run_drain(5'd17, 0, 1'b0);
    run_drain(5'd17, 1, 1'b0);
    // T4: clamp cases, plus the one-lane boundary
    run_drain(5'd0, 0, 1'b0);
    run_drain(5'd31, 1, 1'b0);
    run_drain(5'd1, 0, 1'b0);

    // T5: reset at beat 10
    @(negedge clk);
    start = 1'b1;
    rate_lanes = 5'd25;
    stopout = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_dout", dout, mem[10]);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_push", 64'(pushout), 64'd0);
    chk("mid_rst_dout", dout, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ptr", 64'({mry, mrx}), 64'd0);
    rst = 1'b1;
    begin
      int act;
      act = 0;
      repeat (5) begin
        @(negedge clk);
        if (done || pushout) act++;
      end
      chk("post_rst_quiet", 64'(act), 64'd0);
    end
    run_drain(5'd25, 1, 1'b0);

    // T6: start pulses during SEND and DONE are ignored; next drain starts in
    // the first IDLE cycle after done
    for (int i = 0; i < 25; i++) mem[i] = {$urandom, $urandom};
    run_drain(5'd25, 0, 1'b1);
    run_drain(5'd9, 1, 1'b0);

    @(negedge clk);
    chk("final_idle", 64'({busy, done, pushout}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
